unidade_controle_multiciclo: RTL and testbench
==============================================

Name: unidade_controle_multiciclo

Overview:
Multi-cycle control FSM for the MIPS-subset CPU. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback phases. It supports R-type, LW, SW, BEQ, ADDI and J (opcode 010010), with a wait-state handshake to the unified memory. It replaces the single-cycle decoder when the datapath is built in its multi-cycle form.

Parameters:
INSTR_CNT_W, 32, width of the retired-instruction counter instrCount

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26] from the instruction register; stable from DECODE onward
memReady  input  1  memory completes the current read/write this cycle
pcWrite  output  1  unconditional PC write
pcWriteCond  output  1  PC write if ALU zero
iorD  output  1  memory address select: 0=PC, 1=ALUOut
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  instruction register load
memToReg  output  1  writeback source: 1=MDR, 0=ALUOut
regDst  output  1  destination select: 1=rd, 0=rt
regWrite  output  1  register file write
aluSrcA  output  1  0=PC, 1=regA
aluSrcB  output  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
aluOp  output  2  00=ADD, 01=SUB, 10=funct-decoded
pcSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state (debug)
instrDone  output  1  one-cycle pulse on an instruction's final cycle
instrCount  output  INSTR_CNT_W  retired-instruction counter

Behaviour:
- State register is 4 bits. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12 (TRAP exists only with the optional feature).
- Outputs are decoded from the state register. Only pcWrite, irWrite and instrDone are also qualified by memReady where noted.
- Any output not listed for a state is 0.
- Reset:
  - While reset=1, every control output and instrDone is forced to 0.
  - At the next clock edge, state<=FETCH and instrCount<=0.
  - Reset mid-instruction abandons it; no partial writes occur after the reset edge.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite=pcWrite=memReady.
  - Stay while memReady=0; go to DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precomputed). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 010010 -> JUMP
  - any other opcode -> FETCH (NOP, no instrDone)
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Go to MEMRD if LW, else MEMWR.
- MEMRD: memRead=1, iorD=1. Wait for memReady, then go to MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1, instrDone=1. Go to FETCH.
- MEMWR: memWrite=1, iorD=1. Hold until memReady; instrDone=memReady. Then go to FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Go to ALUWB.
- ALUWB: regDst=1, memToReg=0, regWrite=1, instrDone=1. Go to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1. Go to FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Go to ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1, instrDone=1. Go to FETCH.
- JUMP: pcWrite=1, pcSource=10, instrDone=1. Go to FETCH.
- Latency with memReady held at 1 (cycles including FETCH): R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3. Each memory wait cycle adds exactly 1.
- memWrite and memRead are never asserted together.
- instrCount increments on every instrDone and wraps modulo 2^INSTR_CNT_W.
- Encodings 13–15 are unreachable; if entered, they go to FETCH with all outputs 0.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined:
  - An unrecognised opcode in DECODE goes to TRAP.
  - TRAP drives all control outputs 0, asserts an extra output illegalInstr=1, and holds until reset.
  - The port illegalInstr exists only when the macro is defined.
- Undefined: an unrecognised opcode returns to FETCH as a NOP (see DECODE).

Decomposition:
- Shared package: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), aluOp encodings, aluSrcB/pcSource select encodings, and the state enum typedef.
- One natural sub-module: instr_counter (parameterised wrapping counter with synchronous reset and increment enable).

Test Plan:
- Reset held 3 cycles with memReady=1 -> all controls 0 during reset; state=0 after release; instrCount=0.
- ADD (opcode 000000), memReady=1 -> states 0,1,6,7,0; regWrite=1 and regDst=1 in cycle 4 only; instrDone single pulse; instrCount=1.
- LW (opcode 100011) with memReady low 2 cycles in FETCH and 1 in MEMRD -> 8 total cycles; irWrite/pcWrite only on the FETCH cycle with memReady=1; memToReg=1 in MEMWB.
- SW then BEQ, memReady=1 -> SW takes 4 cycles with memWrite=1 and iorD=1 in cycle 4; BEQ takes 3 cycles with pcWriteCond=1, aluOp=01, pcSource=01; instrCount=2.
- J (opcode 010010) followed by opcode 111111 -> J takes 3 cycles with pcSource=10; the illegal opcode returns to FETCH with no instrDone (macro undefined), or enters state 12 with illegalInstr=1 until reset (macro defined).
- reset asserted in MEMRD of an LW; INSTR_CNT_W=2 with 5 ADDIs -> after the reset edge, state=0 and regWrite is never asserted; instrCount reads 1 after the 5th ADDI (wrap).

Source files
------------

// File: rtl/unidade_controle_multiciclo_pkg.sv
// ============================================================================
// Module      : unidade_controle_multiciclo_pkg
// Description : Shared constants and types for the multi-cycle MIPS-subset
//               control unit: opcodes, ALU/mux select encodings, state enum
//               and the packed control word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package unidade_controle_multiciclo_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b010010;

    // aluOp encodings
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // aluSrcB select encodings
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // pcSource select encodings
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Controller states; S_TRAP is only reachable with ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    // Complete datapath control word, decoded from the state register
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/unidade_controle_multiciclo_if.sv
// ============================================================================
// Module      : unidade_controle_multiciclo_if
// Description : Controller <-> datapath bundle. master = control unit,
//               slave = datapath/observer. illegalInstr is present only when
//               ILLEGAL_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface unidade_controle_multiciclo_if #(
    parameter int INSTR_CNT_W = 32
);
    logic [5:0]             opcode;
    logic                   memReady;
    logic                   pcWrite;
    logic                   pcWriteCond;
    logic                   iorD;
    logic                   memRead;
    logic                   memWrite;
    logic                   irWrite;
    logic                   memToReg;
    logic                   regDst;
    logic                   regWrite;
    logic                   aluSrcA;
    logic [1:0]             aluSrcB;
    logic [1:0]             aluOp;
    logic [1:0]             pcSource;
    logic [3:0]             state;
    logic                   instrDone;
    logic [INSTR_CNT_W-1:0] instrCount;
`ifdef ILLEGAL_TRAP_EN
    logic                   illegalInstr;
`endif

    modport master (
`ifdef ILLEGAL_TRAP_EN
        output illegalInstr,
`endif
        input  opcode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, state, instrDone, instrCount
    );

    modport slave (
`ifdef ILLEGAL_TRAP_EN
        input  illegalInstr,
`endif
        output opcode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, state, instrDone, instrCount
    );
endinterface

`default_nettype wire

// File: rtl/unidade_controle_multiciclo_instr_counter.sv
// ============================================================================
// Module      : instr_counter
// Description : Wrapping up-counter with synchronous active-high reset and
//               increment enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: add one when enabled, natural wrap at 2^WIDTH
    always_comb begin
        count_d = count_q;
        if (i_inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
endmodule

`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
// ============================================================================
// Module      : unidade_controle_multiciclo
// Description : Multi-cycle control FSM for the MIPS-subset CPU (R-type, LW,
//               SW, BEQ, ADDI, J) with memory wait-state handshake and a
//               retired-instruction counter.
//               Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap in
//               state 12 (illegalInstr=1) until reset instead of acting as NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidade_controle_multiciclo
    import unidade_controle_multiciclo_pkg::*;
#(
    parameter int INSTR_CNT_W = 32
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    unidade_controle_multiciclo_if.master bus
);
    state_e state_q;
    state_e state_d;
    ctrl_t  w_ctrl;
`ifdef ILLEGAL_TRAP_EN
    logic   w_illegal;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; reset masks every control so an
    // abandoned instruction cannot write anything
    always_comb begin
        state_d = S_FETCH;
        w_ctrl  = '0;
`ifdef ILLEGAL_TRAP_EN
        w_illegal = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                w_ctrl.memRead = 1'b1;
                w_ctrl.aluSrcB = SRCB_FOUR;
                w_ctrl.irWrite = bus.memReady;
                w_ctrl.pcWrite = bus.memReady;
                state_d        = bus.memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                w_ctrl.aluSrcB = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluSrcB = SRCB_IMM;
                state_d        = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_ctrl.memRead = 1'b1;
                w_ctrl.iorD    = 1'b1;
                state_d        = bus.memReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_ctrl.memToReg  = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_ctrl.instrDone = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.memWrite  = 1'b1;
                w_ctrl.iorD      = 1'b1;
                w_ctrl.instrDone = bus.memReady;
                state_d          = bus.memReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluSrcB = SRCB_REGB;
                w_ctrl.aluOp   = ALU_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                w_ctrl.regDst    = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_ctrl.instrDone = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.aluSrcA     = 1'b1;
                w_ctrl.aluSrcB     = SRCB_REGB;
                w_ctrl.aluOp       = ALU_SUB;
                w_ctrl.pcWriteCond = 1'b1;
                w_ctrl.pcSource    = PC_ALUOUT;
                w_ctrl.instrDone   = 1'b1;
            end
            S_ADDIEX: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluSrcB = SRCB_IMM;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_ctrl.regWrite  = 1'b1;
                w_ctrl.instrDone = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pcWrite   = 1'b1;
                w_ctrl.pcSource  = PC_JUMP;
                w_ctrl.instrDone = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_illegal = 1'b1;
                state_d   = S_TRAP;
            end
`endif
            default: begin
                // Unreachable encodings recover to FETCH with controls idle
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            w_ctrl = '0;
`ifdef ILLEGAL_TRAP_EN
            w_illegal = 1'b0;
`endif
        end
    end

    assign bus.pcWrite     = w_ctrl.pcWrite;
    assign bus.pcWriteCond = w_ctrl.pcWriteCond;
    assign bus.iorD        = w_ctrl.iorD;
    assign bus.memRead     = w_ctrl.memRead;
    assign bus.memWrite    = w_ctrl.memWrite;
    assign bus.irWrite     = w_ctrl.irWrite;
    assign bus.memToReg    = w_ctrl.memToReg;
    assign bus.regDst      = w_ctrl.regDst;
    assign bus.regWrite    = w_ctrl.regWrite;
    assign bus.aluSrcA     = w_ctrl.aluSrcA;
    assign bus.aluSrcB     = w_ctrl.aluSrcB;
    assign bus.aluOp       = w_ctrl.aluOp;
    assign bus.pcSource    = w_ctrl.pcSource;
    assign bus.instrDone   = w_ctrl.instrDone;
    assign bus.state       = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegalInstr = w_illegal;
`endif

    instr_counter #(
        .WIDTH (INSTR_CNT_W)
    ) u_instr_counter (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_ctrl.instrDone),
        .o_count (bus.instrCount)
    );
endmodule

`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
// ============================================================================
// Module      : tb_unidade_controle_multiciclo
// Description : Self-checking bench for the multi-cycle control unit. Two
//               instances (32-bit and 2-bit counters) share one stimulus.
//               Honours ILLEGAL_TRAP_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unidade_controle_multiciclo;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    unidade_controle_multiciclo_if #(.INSTR_CNT_W(32)) bus1 ();
    unidade_controle_multiciclo_if #(.INSTR_CNT_W(2))  bus2 ();

    assign bus2.opcode   = bus1.opcode;
    assign bus2.memReady = bus1.memReady;

    unidade_controle_multiciclo #(.INSTR_CNT_W(32)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    unidade_controle_multiciclo #(.INSTR_CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t c;
        int   st;
        bit   rst;
        int   lit1;
        int   lit2;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          ncyc     = 0;
    int          pend1    = -1;
    int          pend2    = -1;
    logic [31:0] model_count = '0;

    // Controls required in each phase, taken from the phase descriptions
    function automatic ctl_t spec_ctl(int ph, bit rdy);
        ctl_t c = '0;
        case (ph)
            0:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
            1:  begin c.aluSrcB = 2'b11; end
            2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            3:  begin c.memRead = 1; c.iorD = 1; end
            4:  begin c.memToReg = 1; c.regWrite = 1; c.instrDone = 1; end
            5:  begin c.memWrite = 1; c.iorD = 1; c.instrDone = rdy; end
            6:  begin c.aluSrcA = 1; c.aluOp = 2'b10; end
            7:  begin c.regDst = 1; c.regWrite = 1; c.instrDone = 1; end
            8:  begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1;
                      c.pcSource = 2'b01; c.instrDone = 1; end
            9:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            10: begin c.regWrite = 1; c.instrDone = 1; end
            11: begin c.pcWrite = 1; c.pcSource = 2'b10; c.instrDone = 1; end
            12: begin c.illegal = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t act1();
        ctl_t a;
        a.pcWrite     = bus1.pcWrite;
        a.pcWriteCond = bus1.pcWriteCond;
        a.iorD        = bus1.iorD;
        a.memRead     = bus1.memRead;
        a.memWrite    = bus1.memWrite;
        a.irWrite     = bus1.irWrite;
        a.memToReg    = bus1.memToReg;
        a.regDst      = bus1.regDst;
        a.regWrite    = bus1.regWrite;
        a.aluSrcA     = bus1.aluSrcA;
        a.aluSrcB     = bus1.aluSrcB;
        a.aluOp       = bus1.aluOp;
        a.pcSource    = bus1.pcSource;
        a.instrDone   = bus1.instrDone;
`ifdef ILLEGAL_TRAP_EN
        a.illegal     = bus1.illegalInstr;
`else
        a.illegal     = 1'b0;
`endif
        return a;
    endfunction

    // One clock of stimulus plus the outputs required during it
    task automatic cyc(input logic [5:0] op, input bit rdy, input bit rst, input int ph);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus1.opcode   = op;
        bus1.memReady = rdy;
        e.c    = rst ? ctl_t'('0) : spec_ctl(ph, rdy);
        e.st   = ph;
        e.rst  = rst;
        e.lit1 = pend1;
        e.lit2 = pend2;
        pend1  = -1;
        pend2  = -1;
        q.push_back(e);
        ncyc++;
    endtask

    // Whole instruction: phase list per opcode, memory phases get wait cycles
    task automatic run(input logic [5:0] op, input int fw, input int mw, output int n);
        int ph[$];
        int start;
        start = ncyc;
        case (op)
            6'b000000: ph = '{0, 1, 6, 7};
            6'b100011: ph = '{0, 1, 2, 3, 4};
            6'b101011: ph = '{0, 1, 2, 5};
            6'b000100: ph = '{0, 1, 8};
            6'b001000: ph = '{0, 1, 9, 10};
            6'b010010: ph = '{0, 1, 11};
            default:   ph = '{0, 1};
        endcase
        foreach (ph[i]) begin
            if (ph[i] == 0 || ph[i] == 3 || ph[i] == 5) begin
                repeat ((ph[i] == 0) ? fw : mw) cyc(op, 1'b0, 1'b0, ph[i]);
            end
            cyc(op, 1'b1, 1'b0, ph[i]);
        end
        n = ncyc - start;
    endtask

    task automatic check_len(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL len_%s: got %0d cycles, required %0d", name, got, want);
        end
    endtask

    // Compare process: every queued cycle is checked mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            ctl_t a;
            e = q.pop_front();
            a = act1();
            checks++;
            if (a !== e.c) begin
                failures++;
                $display("FAIL ctl @%0t: got %h required %h", $time, a, e.c);
            end
            checks++;
            if (bus1.state !== 4'(e.st)) begin
                failures++;
                $display("FAIL state @%0t: got %0d required %0d", $time, bus1.state, e.st);
            end
            checks++;
            if (bus1.instrCount !== model_count) begin
                failures++;
                $display("FAIL count32 @%0t: got %0d required %0d", $time, bus1.instrCount, model_count);
            end
            checks++;
            if (bus2.instrCount !== model_count[1:0]) begin
                failures++;
                $display("FAIL count2 @%0t: got %0d required %0d", $time, bus2.instrCount, model_count[1:0]);
            end
            if (e.lit1 >= 0) begin
                checks++;
                if (bus1.instrCount !== 32'(e.lit1)) begin
                    failures++;
                    $display("FAIL lit_count32 @%0t: got %0d required %0d", $time, bus1.instrCount, e.lit1);
                end
            end
            if (e.lit2 >= 0) begin
                checks++;
                if (bus2.instrCount !== 2'(e.lit2)) begin
                    failures++;
                    $display("FAIL lit_count2 @%0t: got %0d required %0d", $time, bus2.instrCount, e.lit2);
                end
            end
            if (e.c.instrDone) model_count = model_count + 32'd1;
            if (e.rst) model_count = '0;
        end
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus1.opcode   = 6'b000000;
        bus1.memReady = 1'b1;
        @(posedge clk);

        // Reset held three cycles with memReady high
        pend1 = 0;
        pend2 = 0;
        repeat (3) cyc(6'b000000, 1'b1, 1'b1, 0);

        run(6'b000000, 0, 0, n);  check_len("add", n, 4);
        pend1 = 1;
        run(6'b100011, 2, 1, n);  check_len("lw_wait", n, 8);
        run(6'b101011, 0, 0, n);  check_len("sw", n, 4);
        run(6'b000100, 0, 0, n);  check_len("beq", n, 3);
        pend1 = 4;
        run(6'b010010, 0, 0, n);  check_len("j", n, 3);
        run(6'b111111, 0, 0, n);  check_len("illegal", n, 2);
`ifdef ILLEGAL_TRAP_EN
        repeat (4) cyc(6'b111111, 1'b1, 1'b0, 12);
        pend1 = 5;
        cyc(6'b111111, 1'b1, 1'b1, 12);
`else
        pend1 = 5;
`endif

        // LW abandoned by reset while in MEMRD with memory ready
        cyc(6'b100011, 1'b1, 1'b0, 0);
        cyc(6'b100011, 1'b1, 1'b0, 1);
        cyc(6'b100011, 1'b1, 1'b0, 2);
        cyc(6'b100011, 1'b1, 1'b1, 3);

        pend1 = 0;
        pend2 = 0;
        repeat (5) begin
            run(6'b001000, 0, 0, n);
            check_len("addi", n, 4);
        end
        pend1 = 5;
        pend2 = 1;
        cyc(6'b000000, 1'b0, 1'b0, 0);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
